// File: rtl/kernel_st_packetizer.sv
// Frames an unframed 32-bit Avalon-ST word stream into SOP/EOP/empty packets behind one registered stage.
// Define KERNEL_ST_PACKETIZER_HDR_EN to prefix every packet with a {seq, len} header word.
module kernel_st_packetizer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pkt_len,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic [31:0] pkt_count
);

  typedef enum logic [1:0] {
`ifdef KERNEL_ST_PACKETIZER_HDR_EN
    HDR  = 2'd2,
`endif
    IDLE = 2'd0,
    BODY = 2'd1
  } state_t;

  state_t      state, state_nxt;
  logic [13:0] cnt, cnt_nxt;
  logic [1:0]  empty_last, empty_last_nxt;
  logic [15:0] seq, seq_nxt;

  logic        advance;
  logic        ready_int;
  logic        load;
  logic [31:0] ld_data;
  logic        ld_sop;
  logic        ld_eop;
  logic [1:0]  ld_empty;

  logic [15:0] len;
  logic [15:0] len_m1;
  logic [13:0] words_m1;
  logic [1:0]  empty_new;

  // len-1 gives both ceil(len/4)-1 (upper bits) and the EOP pad (inverted low bits).
  assign len       = (pkt_len == 16'd0) ? 16'd4 : pkt_len;
  assign len_m1    = len - 16'd1;
  assign words_m1  = len_m1[15:2];
  assign empty_new = ~len_m1[1:0];

  assign advance  = out_ready || !out_valid;
  assign in_ready = ready_int && reset_n;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    empty_last_nxt = empty_last;
    seq_nxt        = seq;
    ready_int      = 1'b0;
    load           = 1'b0;
    ld_data        = in_data;
    ld_sop         = 1'b0;
    ld_eop         = 1'b0;
    ld_empty       = 2'd0;

    case (state)
      IDLE: begin
`ifdef KERNEL_ST_PACKETIZER_HDR_EN
        state_nxt = HDR;
`else
        ready_int = advance;
        if (in_valid && advance) begin
          load           = 1'b1;
          ld_sop         = 1'b1;
          empty_last_nxt = empty_new;
          if (words_m1 == 14'd0) begin
            ld_eop   = 1'b1;
            ld_empty = empty_new;
            seq_nxt  = seq + 16'd1;
          end else begin
            cnt_nxt   = words_m1 - 14'd1;
            state_nxt = BODY;
          end
        end
`endif
      end

      BODY: begin
        ready_int = advance;
        if (in_valid && advance) begin
          load = 1'b1;
          if (cnt == 14'd0) begin
            ld_eop   = 1'b1;
            ld_empty = empty_last;
            seq_nxt  = seq + 16'd1;
`ifdef KERNEL_ST_PACKETIZER_HDR_EN
            state_nxt = HDR;
`else
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = cnt - 14'd1;
          end
        end
      end

`ifdef KERNEL_ST_PACKETIZER_HDR_EN
      HDR: begin
        if (advance) begin
          load           = 1'b1;
          ld_data        = {seq, len};
          ld_sop         = 1'b1;
          cnt_nxt        = words_m1;
          empty_last_nxt = empty_new;
          state_nxt      = BODY;
        end
      end
`endif

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= 14'd0;
      empty_last        <= 2'd0;
      seq               <= 16'd0;
      out_valid         <= 1'b0;
      out_data          <= 32'd0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= 2'd0;
      pkt_count         <= 32'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      empty_last <= empty_last_nxt;
      seq        <= seq_nxt;
      if (out_valid && out_ready && out_endofpacket)
        pkt_count <= pkt_count + 32'd1;
      // Stalled outputs hold; an idle advance only drops valid.
      if (advance) begin
        out_valid <= load;
        if (load) begin
          out_data          <= ld_data;
          out_startofpacket <= ld_sop;
          out_endofpacket   <= ld_eop;
          out_empty         <= ld_empty;
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_st_packetizer.sv
// Table-driven bench for kernel_st_packetizer; picks the header or plain vector set from KERNEL_ST_PACKETIZER_HDR_EN.
module tb_kernel_st_packetizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pkt_len;
  logic        in_ready;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;
  logic [31:0] pkt_count;

  int n_pass  = 0;
  int n_total = 0;

  kernel_st_packetizer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pkt_len           (pkt_len),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .pkt_count         (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pkt_len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_sop;
    logic        exp_eop;
    logic [1:0]  exp_empty;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic [15:0] pl, input logic iv, input logic [31:0] d, input logic ordy,
                     input logic er, input logic ev, input logic [31:0] ed, input logic es,
                     input logic ee, input logic [1:0] em, input logic [31:0] ec);
    vec_t v;
    v.pkt_len = pl; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_sop = es;
    v.exp_eop = ee; v.exp_empty = em; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef KERNEL_ST_PACKETIZER_HDR_EN
    // pkt_len=6: header word, two body words, last with empty=2; seq advances per packet.
    add(16'd6, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 32'd0);
    add(16'd6, 1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 2'd0, 32'd0);
    add(16'd6, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1,        1'b0, 1'b0, 2'd0, 32'd0);
    add(16'd6, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h2,        1'b0, 1'b1, 2'd2, 32'd0);
    add(16'd6, 1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 32'h0001_0006, 1'b1, 1'b0, 2'd0, 32'd1);
    add(16'd6, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h3,        1'b0, 1'b0, 2'd0, 32'd1);
    add(16'd6, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h4,        1'b0, 1'b1, 2'd2, 32'd1);
    add(16'd6, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0002_0006, 1'b1, 1'b0, 2'd0, 32'd2);
`else
    // Basic framing, pkt_len=10: three words per packet, empty=2, no bubble.
    add(16'd10, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 2'd0, 32'd0);
    add(16'd10, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0, 2'd0, 32'd0);
    add(16'd10, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h3, 1'b0, 1'b1, 2'd2, 32'd0);
    add(16'd10, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 2'd0, 32'd1);
    add(16'd10, 1'b1, 32'h5, 1'b1, 1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 2'd0, 32'd1);
    add(16'd10, 1'b1, 32'h6, 1'b1, 1'b1, 1'b1, 32'h6, 1'b0, 1'b1, 2'd2, 32'd1);
    add(16'd10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'd2);
    // Single-word packets: pkt_len=4 and pkt_len=0.
    add(16'd4,  1'b1, 32'h7, 1'b1, 1'b1, 1'b1, 32'h7, 1'b1, 1'b1, 2'd0, 32'd2);
    add(16'd0,  1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 2'd0, 32'd3);
    add(16'd0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'd4);
    // Backpressure, pkt_len=8: out_ready 1,0,0,1 holds word 0x9 stable.
    add(16'd8,  1'b1, 32'h9, 1'b1, 1'b1, 1'b1, 32'h9, 1'b1, 1'b0, 2'd0, 32'd4);
    add(16'd8,  1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'h9, 1'b1, 1'b0, 2'd0, 32'd4);
    add(16'd8,  1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'h9, 1'b1, 1'b0, 2'd0, 32'd4);
    add(16'd8,  1'b1, 32'hA, 1'b1, 1'b1, 1'b1, 32'hA, 1'b0, 1'b1, 2'd0, 32'd4);
    add(16'd8,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'd5);
    // Length 9 latched (3 words, empty=3) while pkt_len changes to 4 mid-packet.
    add(16'd9,  1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 2'd0, 32'd5);
    add(16'd4,  1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 2'd0, 32'd5);
    add(16'd4,  1'b1, 32'h12, 1'b1, 1'b1, 1'b1, 32'h12, 1'b0, 1'b1, 2'd3, 32'd5);
    add(16'd4,  1'b1, 32'h13, 1'b1, 1'b1, 1'b1, 32'h13, 1'b1, 1'b1, 2'd0, 32'd6);
    add(16'd5,  1'b1, 32'h14, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 2'd0, 32'd7);
    add(16'd5,  1'b1, 32'h15, 1'b1, 1'b1, 1'b1, 32'h15, 1'b0, 1'b1, 2'd3, 32'd7);
    add(16'd5,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'd8);
`endif

    reset_n   = 1'b0;
    pkt_len   = 16'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  {31'd0, in_ready}, 32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_data",  out_data, 32'd0);
    check("rst.pkt_count", pkt_count, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      pkt_len   = vecs[i].pkt_len;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      check($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d.out_data", i), out_data, vecs[i].exp_data);
        check($sformatf("v%0d.sop", i), {31'd0, out_startofpacket}, {31'd0, vecs[i].exp_sop});
        check($sformatf("v%0d.eop", i), {31'd0, out_endofpacket}, {31'd0, vecs[i].exp_eop});
        check($sformatf("v%0d.empty", i), {30'd0, out_empty}, {30'd0, vecs[i].exp_empty});
      end
      check($sformatf("v%0d.pkt_count", i), pkt_count, vecs[i].exp_cnt);
    end

`ifndef KERNEL_ST_PACKETIZER_HDR_EN
    // Reset mid-packet: pkt_len=16, two words accepted, one-cycle reset pulse.
    @(negedge clk);
    pkt_len = 16'd16; in_valid = 1'b1; in_data = 32'h30; out_ready = 1'b1;
    @(negedge clk);
    in_data = 32'h31;
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("mid_rst.in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst.out_data",  out_data, 32'd0);
    check("mid_rst.sop_eop",   {30'd0, out_startofpacket, out_endofpacket}, 32'd0);
    check("mid_rst.empty",     {30'd0, out_empty}, 32'd0);
    check("mid_rst.pkt_count", pkt_count, 32'd8 - 32'd8);
    reset_n = 1'b1;
    @(negedge clk);
    pkt_len = 16'd4; in_valid = 1'b1; in_data = 32'h20;
    @(posedge clk);
    #1;
    check("restart.out_valid", {31'd0, out_valid}, 32'd1);
    check("restart.out_data",  out_data, 32'h20);
    check("restart.sop_eop",   {30'd0, out_startofpacket, out_endofpacket}, 32'd3);
    check("restart.pkt_count", pkt_count, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("restart.pkt_count_after", pkt_count, 32'd1);
    check("restart.idle_valid", {31'd0, out_valid}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kernel_st_packetizer.md
# kernel_st_packetizer

Frames a continuous, unframed 32-bit Avalon-ST word stream into packets with startofpacket, endofpacket and empty. It sits directly upstream of the kernel's Avalon-ST timing adapter and drives that adapter's 32-bit data, SOP, EOP and 2-bit empty input. The output is a single registered pipeline stage with readyLatency 0. Packet length comes from a byte-count input sampled at each packet start. A compile-time option prepends a header word.

## Interface
Parameters:
- none; all widths are fixed by the downstream 32-bit, 2-bit-empty stream.

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- pkt_len  in  16  packet body length in bytes; sampled at packet start; 0 is treated as 4
- in_ready  out  1  word accepted when in_valid && in_ready
- in_valid  in  1  upstream word valid
- in_data  in  32  upstream word
- out_ready  in  1  downstream ready, readyLatency 0
- out_valid  out  1  output word valid
- out_data  out  32  output word
- out_startofpacket  out  1  first word of packet
- out_endofpacket  out  1  last word of packet
- out_empty  out  2  unused bytes in the EOP word; 0 on non-EOP words
- pkt_count  out  32  packets completed downstream (EOP word accepted); wraps at 2^32

## Operation
- **Length decode.** At packet start:
  - words = ceil(len/4), where len = (pkt_len==0 ? 4 : pkt_len)
  - empty_last = (4 − len mod 4) mod 4
  - Both are latched for the whole packet; pkt_len changes mid-packet are ignored.
- **Word counter.** 14-bit remaining-word counter, loaded with words−1 at packet start and decremented on each body word loaded into the output register. The EOP word is the load with counter==0.
- **Advance.** advance = out_ready || !out_valid. The output register loads only when advance is high.
- **States:**
  - IDLE: no packet open.
    - With header enabled: goes to HDR unconditionally after reset.
    - Otherwise: on the first accepted word, loads it with SOP=1 and goes to BODY; if words==1, also EOP=1 and stays IDLE.
  - HDR (header build only): when advance is high, loads the header word {seq[15:0], len[15:0]} with SOP=1, EOP=0, then goes to BODY. in_ready=0 in this state.
  - BODY: each accepted word is loaded with SOP=0. The last word has EOP=1 and empty=empty_last, then returns to IDLE (no header) or HDR (header build).
- **in_ready** = advance && (state != HDR).
- **Output register.** When advance is high and no word is accepted, out_valid clears. While out_valid && !out_ready, all out_* are held stable.
- **seq.** 16-bit, increments after each packet's EOP load, wraps 0xFFFF→0.
- **pkt_count.** Increments on the cycle out_valid && out_ready && out_endofpacket.

## Timing
- **Reset** (reset_n low at a clk edge):
  - Outputs: out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, pkt_count and in_ready all 0.
  - Internal: state=IDLE, seq=0, word counter=0.
  - A reset mid-packet drops the partial packet. No EOP is emitted for it.
- **Latency:** a word accepted in cycle N is on the outputs in cycle N+1.
- **Throughput:**
  - No header: 1 word/cycle, back-to-back packets with no bubble.
  - Header: one in_ready-low cycle per packet.
- **Single-word packet** (len ≤ 4): SOP and EOP are asserted on the same word.
- **Simultaneous events:** an EOP handshake and a new packet's first word in the same cycle are legal.

## Configuration
- **KERNEL_ST_PACKETIZER_HDR_EN defined:**
  - HDR state exists.
  - Every packet is prefixed by the header word {seq, len} carrying SOP.
  - Packet length on the wire is words+1.
  - The header word has empty=0.
- **Undefined:**
  - HDR state and its header logic are absent.
  - SOP is on the first data word.
  - The seq register still counts.

## Test plan
- **Basic framing:** pkt_len=10, no header, feed 0x1..0x6 continuously with out_ready=1.
  - Packet 1: 0x1 SOP, 0x2, 0x3 EOP empty=2.
  - Packet 2: 0x4 SOP, 0x5, 0x6 EOP empty=2.
  - No bubble between packets; pkt_count=2.
- **Single word and zero length:** pkt_len=4, then pkt_len=0.
  - Each word carries SOP=EOP=1, empty=0.
- **Backpressure:** pkt_len=8, out_ready toggles 1,0,0,1.
  - in_ready follows advance.
  - Outputs stay stable while stalled.
  - Both words are delivered in order, none lost or duplicated.
- **Header build:** pkt_len=6, HDR_EN defined, two packets.
  - Packet 1: header 0x0000_0006 SOP, 2 body words, last with empty=2.
  - Packet 2: header 0x0001_0006.
  - in_ready=0 on each header cycle.
- **Reset mid-packet:** pkt_len=16, accept 2 words, then pulse reset_n low for one cycle.
  - All outputs are 0 the cycle after reset.
  - The next packet restarts with SOP, seq=0, pkt_count=0.
- **Mid-packet length change:** change pkt_len mid-packet.
  - The current packet keeps its latched length.
  - The next packet uses the new value.
